// File: rtl/gpio_bus_pkg.sv
// gpio_bus_pkg
//   Shared definitions for the GPIO register bus: host command opcodes,
//   the bus master FSM state encoding and the register file word map.
//   Used by gpio_reg_master, the register block and their benches.
package gpio_bus_pkg;

   // Host command opcodes (cmd_op)
   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_SET   = 2'b10,
      OP_CLR   = 2'b11
   } cmd_op_t;

   // Bus master sequencing states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } master_state_t;

   // GPIO register word addresses (bus addr[4:2])
   localparam logic [2:0] GPIO_ADDR_DATA_IN  = 3'd0;
   localparam logic [2:0] GPIO_ADDR_DATA_OUT = 3'd1;
   localparam logic [2:0] GPIO_ADDR_DIR      = 3'd2;
   localparam logic [2:0] GPIO_ADDR_IRQ_EN   = 3'd3;
   localparam logic [2:0] GPIO_ADDR_IRQ_STAT = 3'd4;
   localparam logic [2:0] GPIO_ADDR_IRQ_POL  = 3'd5;
   localparam logic [2:0] GPIO_ADDR_PULL     = 3'd6;
   localparam logic [2:0] GPIO_ADDR_CFG      = 3'd7;

endpackage

// File: rtl/gpio_reg_master.sv
// gpio_reg_master
//   Bus initiator for the GPIO register file. Accepts one command at a
//   time (READ, WRITE, SET, CLR) on a valid/ready host port and sequences
//   it onto the register file bus. SET/CLR are an atomic read-modify-write.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     host command handshake
//   cmd_op/addr/wben/wdata  command fields (wdata is the mask for SET/CLR)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata               read data, pre-modify value, or 0 for WRITE
//   addr/wben/r_wn/wdata    register file bus outputs (all registered)
//   rdata                   register file read data
//
// Bus outputs are registered from the current state, so the write strobe
// becomes visible one cycle after the FSM enters WR; this gives the address
// a full setup cycle ahead of every strobe.
module gpio_reg_master
   import gpio_bus_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [2:0]  cmd_addr,
   input  logic [3:0]  cmd_wben,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic [2:0]  addr,
   output logic [3:0]  wben,
   output logic        r_wn,
   output logic [31:0] wdata,
   input  logic [31:0] rdata
);

   localparam logic [1:0] RD_RELOAD = 2'(RD_LATENCY - 1);

   master_state_t state_r;
   master_state_t state_s;
   logic [1:0]    cnt_r;
   cmd_op_t       op_r;
   logic [3:0]    wben_l_r;
   logic [31:0]   mask_r;
   logic          accept_s;
   logic          retire_s;

   assign accept_s = (state_r == ST_IDLE) && cmd_valid && cmd_ready;
   assign retire_s = (state_r == ST_RESP) && rsp_valid && rsp_ready;

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_s = (cmd_op == OP_WRITE) ? ST_WR : ST_RD;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_RD: begin
            if (cnt_r == 2'd0) begin
               state_s = (op_r == OP_READ) ? ST_RESP : ST_WR;
            end else begin
               state_s = ST_RD;
            end
         end
         ST_WR: begin
            state_s = ST_RESP;
         end
         ST_RESP: begin
            if (retire_s) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register and read-latency counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= 2'd0;
      end else begin
         state_r <= state_s;
         if (accept_s) begin
            cnt_r <= RD_RELOAD;
         end else if ((state_r == ST_RD) && (cnt_r != 2'd0)) begin
            cnt_r <= cnt_r - 2'd1;
         end
      end
   end

   // Command latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r     <= OP_READ;
         wben_l_r <= 4'b0000;
         mask_r   <= 32'h0000_0000;
      end else if (accept_s) begin
         op_r     <= cmd_op_t'(cmd_op);
         wben_l_r <= cmd_wben;
         mask_r   <= cmd_wdata;
      end
   end

   // Registered host-side and bus-side outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'h0000_0000;
         addr      <= 3'd0;
         wben      <= 4'b0000;
         r_wn      <= 1'b1;
         wdata     <= 32'h0000_0000;
      end else begin
         cmd_ready <= (state_s == ST_IDLE);
         rsp_valid <= (state_r == ST_RESP) && !retire_s;
         r_wn      <= (state_r != ST_WR);
         wben      <= (state_r == ST_WR) ? wben_l_r : 4'b0000;
         if (accept_s) begin
            addr <= cmd_addr;
         end
         // rsp_rdata doubles as the captured pre-modify value for SET/CLR
         if (accept_s) begin
            rsp_rdata <= 32'h0000_0000;
         end else if ((state_r == ST_RD) && (cnt_r == 2'd0)) begin
            rsp_rdata <= rdata;
         end
         if (state_r == ST_WR) begin
            case (op_r)
               OP_SET:  wdata <= rsp_rdata | mask_r;
               OP_CLR:  wdata <= rsp_rdata & ~mask_r;
               default: wdata <= mask_r;
            endcase
         end
      end
   end

endmodule

// File: doc/gpio_reg_master.md
# gpio_reg_master

Bus initiator for the GPIO register file: accepts single-register commands (read, write, bit-set, bit-clear) from a host-side valid/ready port and sequences them onto the register file's addr/wben/r_wn/wdata/rdata interface. Bit-set and bit-clear run as an atomic read-modify-write, so firmware-side logic and the interrupt path can update individual pins without racing. The block sits between the host command source (bus bridge or CPU glue) and the `register` block.

## Interface
Parameters:
- RD_LATENCY, default 1: clock edges from addr presented with r_wn=1 to valid rdata at the register file. Legal range 1..4.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  master idle and able to accept a command
- cmd_op  in  2  00 READ, 01 WRITE, 10 SET, 11 CLR
- cmd_addr  in  3  register word address, drives bus addr[4:2]
- cmd_wben  in  4  byte write enables for WRITE/SET/CLR
- cmd_wdata  in  32  write data (WRITE) or bit mask (SET/CLR)
- rsp_valid  out  1  response available
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  32  read data (READ), pre-modify value (SET/CLR), 0 (WRITE)
- addr  out  3  register file address [4:2]
- wben  out  4  register file byte write enables
- r_wn  out  1  1 = read, 0 = write
- wdata  out  32  register file write data
- rdata  in  32  register file read data

## Operation
- States: IDLE, RD (RD_LATENCY cycles), WR (1 cycle), RESP.
- IDLE: cmd_ready=1, r_wn=1, wben=0. Handshake cmd_valid&&cmd_ready latches op/addr/wben/wdata; addr output takes latched cmd_addr on that edge.
- READ: IDLE -> RD -> RESP; rdata captured into rsp_rdata on the last RD edge.
- WRITE: IDLE -> WR -> RESP; WR drives r_wn=0, wben=cmd_wben, wdata=cmd_wdata for exactly one cycle. wben=0 still performs the WR cycle (no-op at target) and responds.
- SET/CLR: IDLE -> RD -> WR -> RESP; captured old value V; WR drives wdata=V|mask (SET) or V&~mask (CLR), wben=cmd_wben; rsp_rdata=V.
- RESP: rsp_valid=1, rsp_rdata stable until rsp_valid&&rsp_ready; then IDLE. Bus idle (r_wn=1, wben=0) in RESP.
- cmd_ready=0 in every state except IDLE; cmd_valid outside IDLE is ignored and must be held by host.
- RD counter 2 bits, reloads RD_LATENCY-1 on entry, exits RD at 0.
- Bus outputs addr/wdata hold last value when idle; only wben and r_wn return to idle values.

## Timing
- Accept at edge N. rsp_valid rises at edge N+1+RD_LATENCY (READ), N+2 (WRITE), N+2+RD_LATENCY (SET/CLR).
- Write strobe (r_wn=0, wben!=0) is exactly one cycle per command; never asserted during RD.
- rsp_ready high in the same cycle rsp_valid rises: response retires on the next edge; cmd_ready rises that edge; minimum one bubble between back-to-back commands.
- Reset values (async, all outputs registered): cmd_ready=1, rsp_valid=0, rsp_rdata=0, addr=0, wben=0, r_wn=1, wdata=0, state=IDLE. Commands presented while reset is high are not accepted.
- Reset mid-operation: command aborted, no response, bus forced to r_wn=1/wben=0 immediately; an in-flight RMW may leave the target unmodified but never half-written.

## Structure
- Package gpio_bus_pkg: cmd_op encodings, FSM state enum, GPIO register address constants (shared with `register` and its bench).
- Single module, no sub-module; RMW merge is one line of combinational logic inside the WR output register.

## Test plan
- Reset held 3 cycles then released -> all outputs at reset values, cmd_ready=1 first cycle after release.
- WRITE addr=3'b110 wben=4'b0011 wdata=32'hFFFF9249 -> one cycle r_wn=0 at N+1, rsp_valid at N+2, rsp_rdata=0; register model holds 0x00009249 in low half.
- READ addr=3'b110 after above, RD_LATENCY=1 -> rsp_rdata=32'h00009249 at N+2.
- SET addr=3'b110 mask=32'h00000006 wben=4'b0001 on 0x00009249 -> write cycle wdata=0x0000924F, rsp_rdata=0x00009249; follow-up CLR mask 0x1 -> register 0x0000924E.
- cmd_valid held during busy plus rsp_ready held low 5 cycles -> second command not accepted until response retires; rsp_rdata stable throughout.
- Reset asserted in WR cycle of a SET -> r_wn=1, wben=0 same cycle, rsp_valid never asserts, cmd_ready=1 after release.
